// File: rtl/banner_scroll.sv
// banner_scroll: scrolling message on a 4-digit multiplexed seven-segment
// display (common anode, active-low). One digit refreshes per tick_display,
// and the scroll position advances once per tick_banner.
module banner_scroll #(
  parameter int MSG_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_display,
  input  logic          tick_banner,
  input  logic          pause,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_data,
  output logic [6:0]    seg,
  output logic [3:0]    anode,
  output logic [AW-1:0] pos
);

  localparam logic [AW:0]   LEN_W = (AW+1)'(MSG_LEN);
  localparam logic [AW-1:0] LAST  = AW'(MSG_LEN - 1);

  logic [4:0]    msg [MSG_LEN];
  logic [1:0]    dsel;
  logic [1:0]    dsel_next;
  logic [AW:0]   fetch_sum;
  logic [AW:0]   fetch_wrap;
  logic [AW-1:0] fetch_idx;
  logic [4:0]    fetch_char;
  logic [6:0]    fetch_seg;

  // Message storage: per-character flops so reset can restore the default text.
  // Out-of-range addresses match no element, so such writes fall away.
  for (genvar g = 0; g < MSG_LEN; g++) begin : g_msg
    localparam logic [4:0] INIT = (g == 0) ? 5'd17 :
                                  (g == 1) ? 5'd0  :
                                  (g == 2) ? 5'd18 :
                                  (g == 3) ? 5'd10 : 5'd16;
    // Reset to the default text, otherwise accept writes to this index.
    always_ff @(posedge clk) begin
      if (!rst) begin
        msg[g] <= INIT;
      end else if (wr_en && (wr_addr == AW'(g))) begin
        msg[g] <= wr_data;
      end
    end
  end

  // Digit that the next refresh will drive.
  always_comb dsel_next = dsel + 2'd1;

  // Character index for the next digit: (pos + 3 - dsel_next) mod MSG_LEN.
  // The sum never reaches 2*MSG_LEN, so a single conditional subtract wraps it.
  always_comb begin
    fetch_sum = {1'b0, pos} + {{(AW-1){1'b0}}, 2'd3 - dsel_next};
    if (fetch_sum >= LEN_W) begin
      fetch_wrap = fetch_sum - LEN_W;
    end else begin
      fetch_wrap = fetch_sum;
    end
    fetch_idx  = fetch_wrap[AW-1:0];
    fetch_char = msg[fetch_idx];
  end

  // Character code to active-low segment pattern {g,f,e,d,c,b,a}.
  always_comb begin
    unique case (fetch_char)
      5'd0:    fetch_seg = 7'b1000000;
      5'd1:    fetch_seg = 7'b1111001;
      5'd2:    fetch_seg = 7'b0100100;
      5'd3:    fetch_seg = 7'b0110000;
      5'd4:    fetch_seg = 7'b0011001;
      5'd5:    fetch_seg = 7'b0010010;
      5'd6:    fetch_seg = 7'b0000010;
      5'd7:    fetch_seg = 7'b1111000;
      5'd8:    fetch_seg = 7'b0000000;
      5'd9:    fetch_seg = 7'b0010000;
      5'd10:   fetch_seg = 7'b0001000;
      5'd11:   fetch_seg = 7'b0000011;
      5'd12:   fetch_seg = 7'b1000110;
      5'd13:   fetch_seg = 7'b0100001;
      5'd14:   fetch_seg = 7'b0000110;
      5'd15:   fetch_seg = 7'b0001110;
      5'd17:   fetch_seg = 7'b0001001;
      5'd18:   fetch_seg = 7'b1000111;
      5'd19:   fetch_seg = 7'b0001100;
      5'd20:   fetch_seg = 7'b1000001;
      5'd21:   fetch_seg = 7'b0111111;
      default: fetch_seg = 7'b1111111;
    endcase
  end

  // Digit scan and scroll; the fetch uses the pre-update pos and buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos   <= '0;
      dsel  <= 2'd3;
      anode <= '1;
      seg   <= '1;
    end else begin
      if (tick_display) begin
        dsel  <= dsel_next;
        anode <= ~(4'b0001 << dsel_next);
        seg   <= fetch_seg;
      end
      if (tick_banner && !pause) begin
        pos <= (pos == LAST) ? '0 : pos + AW'(1);
      end
    end
  end

endmodule

// File: doc/banner_scroll.md
Name: banner_scroll

Overview:
- Downstream consumer of the tick generator: takes the single-cycle `tick_display` and `tick_banner` strobes.
- Drives a 4-digit multiplexed seven-segment display (common anode, active-low segments and anodes).
- Holds a writable message buffer of character codes. Advances the scroll position once per `tick_banner` and refreshes one digit per `tick_display`.

Parameters:
- MSG_LEN, 16, number of characters in the message buffer; legal range 4..16.
- AW, 4, width of `wr_addr` and `pos`; must satisfy 2^AW >= MSG_LEN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low (rst=0 resets on the clk edge)
- tick_display  input  1  one-cycle strobe; refresh the next digit
- tick_banner  input  1  one-cycle strobe; scroll one character
- pause  input  1  1 = hold scroll position
- wr_en  input  1  write strobe into the message buffer
- wr_addr  input  AW  buffer index to write
- wr_data  input  5  character code to write
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- anode  output  4  digit enables, active-low one-hot, registered; anode[3] = leftmost
- pos  output  AW  current scroll position (index of leftmost character)

Behaviour:
- Reset (rst=0 at clk edge), overriding everything else:
  - pos=0, dsel=3, anode=4'b1111, seg=7'b1111111.
  - Buffer reloads its default: [0]=H(17), [1]=0(0), [2]=L(18), [3]=A(10), all others blank(16).
  - Reset mid-operation behaves identically; pending strobes in that cycle are dropped.
- Character codes:
  - 0-9 are digits; 10-15 are A-F.
  - 16=blank, 17=H, 18=L, 19=P, 20=U, 21='-'.
  - Codes 22-31 display blank.
- Segment patterns:
  - 0=1000000, 1=1111001, A=0001000, H=0001001, L=1000111, '-'=0111111, blank=1111111.
  - The rest follow standard seven-segment shapes.
- Digit scan:
  - On a cycle with tick_display=1, dsel <= (dsel+1) mod 4.
  - Same edge: anode <= one-hot-low at the new dsel; seg <= decode(buf[(pos + 3 - new_dsel) mod MSG_LEN]).
  - Latency is one clock from the tick cycle to valid outputs.
  - Outputs hold between ticks.
  - Mapping: anode[3] shows buf[pos], anode[2] buf[pos+1], anode[1] buf[pos+2], anode[0] buf[pos+3], all modulo MSG_LEN.
- Scroll:
  - On tick_banner=1 with pause=0: pos <= (pos == MSG_LEN-1) ? 0 : pos+1.
  - With pause=1 the strobe is discarded, not queued.
- Simultaneous tick_display and tick_banner: the digit fetch uses the pre-update pos; the new pos is visible from the next tick_display.
- Writes:
  - wr_en=1 with wr_addr < MSG_LEN writes wr_data at the edge.
  - wr_addr >= MSG_LEN: write ignored, no other side effect.
  - A write coinciding with tick_display to the fetched index: the display shows the old value (read-before-write); the new value appears on the next refresh of that digit.
- No combinational path from any input to seg/anode/pos.
- Buffer is flip-flop based so it is resettable.

Test Plan:
- Reset check: hold rst=0 for 2 clocks, then release.
  - Required: anode=1111, seg=1111111, pos=0.
  - Required: these values hold with no ticks.
- Scan check: issue 4 tick_display pulses 10 clocks apart.
  - Required, one clock after each pulse in order: anode 1110/seg 0001000 (A), then 1101/1000111 (L), then 1011/1000000 (0), then 0111/0001001 (H).
  - Required: the 5th pulse returns to anode 1110.
- Scroll and wrap: 14 tick_banner pulses, then one tick_display landing on dsel=0.
  - Required: pos=14 and seg shows buf[1] = 1000000.
  - Required: 2 more pulses give pos=0 (wrap from 15).
- Pause: pause=1 plus 5 tick_banner pulses, then pause=0 plus 1 pulse.
  - Required: pos unchanged during pause, then +1 after.
  - Required: tick_banner and tick_display in the same cycle uses the old pos for that digit.
- Writes: write addr 3 data 21 coincident with a tick_display fetching index 3.
  - Required: that fetch shows A (0001000); the next fetch of index 3 shows 0111111.
  - Required: with MSG_LEN=12, a write to addr 13 changes nothing.
  - Required: data 25 displays blank.
- Mid-operation reset: after writes and pos=7, drive rst=0 for one cycle.
  - Required: pos=0, outputs at reset values, buffer restored to H,0,L,A and blanks.
